// File: rtl/line_fragment_gen.sv
// Bresenham line rasteriser producing framebuffer fragments.
// One step per cycle under a valid/ready output register.
module line_fragment_gen #(
  parameter int WIDTH   = 13,
  parameter int COLOR_W = 1,
  parameter int FB_COLS = 320,
  parameter int FB_ROWS = 240,
  parameter int FB_W    = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x0,
  input  logic [WIDTH-1:0]   y0,
  input  logic [WIDTH-1:0]   x1,
  input  logic [WIDTH-1:0]   y1,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  input  logic               frag_ready,
  output logic               frag_valid,
  output logic [FB_W-1:0]    FB_addr,
  output logic [COLOR_W-1:0] red_out,
  output logic [COLOR_W-1:0] green_out,
  output logic [COLOR_W-1:0] blue_out,
  output logic               busy,
  output logic               finish
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DRAW,
    S_DONE
  } state_e;

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH:0]   REM1   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   COLS_L = (WIDTH+1)'(FB_COLS);
  localparam logic [WIDTH:0]   ROWS_L = (WIDTH+1)'(FB_ROWS);
  localparam logic [FB_W-1:0]  COLS_A = FB_W'(FB_COLS);

  state_e state_q;

  logic [WIDTH-1:0] ax0_q, ay0_q, ax1_q, ay1_q;
  logic [COLOR_W-1:0] cr_q, cg_q, cb_q;

  logic [WIDTH-1:0] x_q, y_q, dx_q, dy_q;
  logic signed [WIDTH:0] err_q;
  logic [WIDTH:0] rem_q;
  logic steep_q, up_q;

  logic fv_q, busy_q, fin_q;
  logic [FB_W-1:0] addr_q;
  logic [COLOR_W-1:0] ro_q, go_q, bo_q;

  logic [WIDTH-1:0] adx, ady;
  logic su_steep;
  logic [WIDTH-1:0] p0x, p0y, p1x, p1y;
  logic [WIDTH-1:0] xs, ys, xe, ye;
  logic [WIDTH-1:0] su_dx, su_dy;
  logic su_up;
  logic signed [WIDTH:0] su_err;

  logic [WIDTH-1:0] col, row;
  logic in_fb;
  logic [FB_W-1:0] addr_d;
  logic signed [WIDTH:0] err_sub, err_d;
  logic [WIDTH-1:0] y_d;
  logic free, more;

  // Octant normalisation of the captured endpoints
  always_comb begin
    adx = (ax1_q >= ax0_q) ? ax1_q - ax0_q : ax0_q - ax1_q;
    ady = (ay1_q >= ay0_q) ? ay1_q - ay0_q : ay0_q - ay1_q;
    su_steep = ady > adx;
    p0x = su_steep ? ay0_q : ax0_q;
    p0y = su_steep ? ax0_q : ay0_q;
    p1x = su_steep ? ay1_q : ax1_q;
    p1y = su_steep ? ax1_q : ay1_q;
    if (p0x > p1x) begin
      xs = p1x;
      ys = p1y;
      xe = p0x;
      ye = p0y;
    end else begin
      xs = p0x;
      ys = p0y;
      xe = p1x;
      ye = p1y;
    end
    su_dx  = xe - xs;
    su_dy  = (ye >= ys) ? ye - ys : ys - ye;
    su_up  = ys < ye;
    su_err = $signed({2'b00, su_dx[WIDTH-1:1]});
  end

  // Current plot position, clipping, address and next error term
  always_comb begin
    col     = steep_q ? y_q : x_q;
    row     = steep_q ? x_q : y_q;
    in_fb   = ({1'b0, col} < COLS_L) && ({1'b0, row} < ROWS_L);
    addr_d  = FB_W'(row) * COLS_A + FB_W'(col);
    err_sub = err_q - $signed({1'b0, dy_q});
    if (err_sub[WIDTH]) begin
      err_d = err_sub + $signed({1'b0, dx_q});
      y_d   = up_q ? y_q + ONE : y_q - ONE;
    end else begin
      err_d = err_sub;
      y_d   = y_q;
    end
    free = !fv_q || frag_ready;
    more = rem_q != '0;
  end

  // Control FSM with datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ax0_q   <= '0;
      ay0_q   <= '0;
      ax1_q   <= '0;
      ay1_q   <= '0;
      cr_q    <= '0;
      cg_q    <= '0;
      cb_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      rem_q   <= '0;
      steep_q <= 1'b0;
      up_q    <= 1'b0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      addr_q  <= '0;
      ro_q    <= '0;
      go_q    <= '0;
      bo_q    <= '0;
    end else begin
      fin_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ax0_q   <= x0;
            ay0_q   <= y0;
            ax1_q   <= x1;
            ay1_q   <= y1;
            cr_q    <= red_in;
            cg_q    <= green_in;
            cb_q    <= blue_in;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          x_q     <= xs;
          y_q     <= ys;
          dx_q    <= su_dx;
          dy_q    <= su_dy;
          err_q   <= su_err;
          up_q    <= su_up;
          steep_q <= su_steep;
          rem_q   <= {1'b0, su_dx} + REM1;
          state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (free && more) begin
            x_q   <= x_q + ONE;
            y_q   <= y_d;
            err_q <= err_d;
            rem_q <= rem_q - REM1;
            fv_q  <= in_fb;
            if (in_fb) begin
              addr_q <= addr_d;
              ro_q   <= cr_q;
              go_q   <= cg_q;
              bo_q   <= cb_q;
            end
          end else if (free) begin
            fv_q    <= 1'b0;
            fin_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign frag_valid = fv_q;
  assign FB_addr    = addr_q;
  assign red_out    = ro_q;
  assign green_out  = go_q;
  assign blue_out   = bo_q;
  assign busy       = busy_q;
  assign finish     = fin_q;

endmodule

// File: tb/tb_line_fragment_gen.sv
// Directed vector bench for line_fragment_gen.
// Table of lines plus stall, reset and held-start sequences.
module tb_line_fragment_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [12:0] x0, y0, x1, y1;
  logic        red_in, green_in, blue_in;
  logic        frag_ready;
  logic        frag_valid;
  logic [16:0] FB_addr;
  logic        red_out, green_out, blue_out;
  logic        busy;
  logic        finish;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [12:0]      x0;
    logic [12:0]      y0;
    logic [12:0]      x1;
    logic [12:0]      y1;
    logic [2:0]       n;
    logic [3:0][16:0] a;
    logic [2:0]       rgb;
  } vec_t;

  vec_t vt [7];

  line_fragment_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .red_in     (red_in),
    .green_in   (green_in),
    .blue_in    (blue_in),
    .frag_ready (frag_ready),
    .frag_valid (frag_valid),
    .FB_addr    (FB_addr),
    .red_out    (red_out),
    .green_out  (green_out),
    .blue_out   (blue_out),
    .busy       (busy),
    .finish     (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int ax0, input int ay0,
                              input int ax1, input int ay1,
                              input int n, input int a0,
                              input int a1, input int a2,
                              input int a3, input int rgb);
    vec_t v;
    v.x0   = 13'(ax0);
    v.y0   = 13'(ay0);
    v.x1   = 13'(ax1);
    v.y1   = 13'(ay1);
    v.n    = 3'(n);
    v.a[0] = 17'(a0);
    v.a[1] = 17'(a1);
    v.a[2] = 17'(a2);
    v.a[3] = 17'(a3);
    v.rgb  = 3'(rgb);
    return v;
  endfunction

  task automatic load(input vec_t v);
    x0 = v.x0;
    y0 = v.y0;
    x1 = v.x1;
    y1 = v.y1;
    {red_in, green_in, blue_in} = v.rgb;
  endtask

  task automatic run_line(input vec_t v, input int stall_at,
                          input bit chk_lat);
    int got, cyc, fin_n, first, stalls;
    logic [16:0] exp;
    @(negedge clk);
    load(v);
    start      = 1'b1;
    frag_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; got = 0; fin_n = 0; first = -1; stalls = 0;
    while (cyc < 60 && fin_n == 0) begin
      @(posedge clk);
      #1 cyc++;
      if (finish) begin
        fin_n++;
        chk("valid_at_finish", 32'(frag_valid), 0);
      end
      if (frag_valid) begin
        if (first < 0) first = cyc;
        exp = (got < 4) ? v.a[got] : '1;
        if (got == stall_at && stalls < 3) begin
          frag_ready = 1'b0;
          stalls++;
          chk("hold_addr", 32'(FB_addr), 32'(exp));
        end else begin
          frag_ready = 1'b1;
          chk("addr", 32'(FB_addr), 32'(exp));
          chk("rgb", 32'({red_out, green_out, blue_out}), 32'(v.rgb));
          got++;
        end
      end else begin
        frag_ready = 1'b1;
      end
    end
    chk("finish_seen", 32'(fin_n), 1);
    chk("frag_count", 32'(got), 32'(v.n));
    if (chk_lat) chk("first_latency", 32'(first), 2);
    if (stall_at >= 0) chk("stall_cycles", 32'(stalls), 3);
    @(posedge clk);
    #1;
    chk("finish_width", 32'(finish), 0);
    chk("busy_after", 32'(busy), 0);
  endtask

  initial begin
    int got, cyc, fin_n;
    bit seen_fin;
    vt[0] = mk(0, 0, 3, 0, 4, 0, 1, 2, 3, 5);
    vt[1] = mk(5, 10, 6, 13, 4, 3205, 3525, 3846, 4166, 7);
    vt[2] = mk(3, 0, 0, 0, 4, 0, 1, 2, 3, 2);
    vt[3] = mk(7, 2, 7, 2, 1, 647, 0, 0, 0, 4);
    vt[4] = mk(318, 0, 321, 0, 2, 318, 319, 0, 0, 1);
    vt[5] = mk(0, 0, 3, 2, 4, 0, 321, 322, 643, 6);
    vt[6] = mk(0, 2, 3, 0, 4, 640, 321, 322, 3, 3);

    rst        = 1'b0;
    start      = 1'b0;
    frag_ready = 1'b1;
    load(vt[0]);
    #1;
    chk("rst_valid", 32'(frag_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finish", 32'(finish), 0);
    chk("rst_addr", 32'(FB_addr), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_line(vt[i], -1, i == 0);

    run_line(vt[0], 1, 1'b0);

    // Reset in the middle of a line
    @(negedge clk);
    load(vt[0]);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("mid_valid_pre", 32'(frag_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(frag_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_finish", 32'(finish), 0);
    chk("arst_addr", 32'(FB_addr), 0);
    chk("arst_rgb", 32'({red_out, green_out, blue_out}), 0);
    seen_fin = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 if (finish) seen_fin = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 if (finish || busy || frag_valid) seen_fin = 1'b1;
    end
    chk("no_finish_after_rst", 32'(seen_fin), 0);
    run_line(vt[1], -1, 1'b1);

    // start held high across a whole line
    @(negedge clk);
    load(vt[0]);
    start      = 1'b1;
    frag_ready = 1'b1;
    got = 0; cyc = 0; fin_n = 0;
    while (cyc < 40 && fin_n == 0) begin
      @(posedge clk);
      #1 cyc++;
      if (frag_valid) got++;
      if (finish) fin_n++;
    end
    chk("held_finish", 32'(fin_n), 1);
    chk("held_count", 32'(got), 4);
    @(posedge clk);
    #1 chk("held_idle", 32'(busy), 0);
    @(posedge clk);
    #1 chk("held_restart", 32'(busy), 1);
    start = 1'b0;
    cyc = 0; fin_n = 0;
    while (cyc < 40 && fin_n == 0) begin
      @(posedge clk);
      #1 cyc++;
      if (finish) fin_n++;
    end
    chk("held_second_finish", 32'(fin_n), 1);
    @(posedge clk);
    #1 chk("held_end_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_fragment_gen.md
LINE_FRAGMENT_GEN -- requirements
Module: line_fragment_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 13: coordinate width, unsigned.
REQ-002 SHALL have parameter COLOR_W, default 1: width of each colour channel.
REQ-003 SHALL have parameter FB_COLS, default 320: framebuffer columns.
REQ-004 SHALL have parameter FB_ROWS, default 240: framebuffer rows.
REQ-005 SHALL have parameter FB_W, default 17: framebuffer address width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port start, input, 1 bit: line request, sampled only in IDLE.
REQ-009 SHALL have ports x0, y0, x1, y1, input, WIDTH each: line endpoints, captured at start.
REQ-010 SHALL have ports red_in, green_in, blue_in, input, COLOR_W each: line colour, captured at start.
REQ-011 SHALL have port frag_ready, input, 1 bit: downstream accepts the fragment.
REQ-012 SHALL have port frag_valid, output, 1 bit: fragment present.
REQ-013 SHALL have port FB_addr, output, FB_W: fragment address.
REQ-014 SHALL have ports red_out, green_out, blue_out, output, COLOR_W each: fragment colour.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port finish, output, 1 bit: one-cycle pulse at the end of a line.

Function
REQ-017 SHALL implement FSM IDLE -> SETUP -> DRAW -> DONE -> IDLE, with DONE lasting exactly 1 cycle.
REQ-018 SHALL, in IDLE with start=1, capture endpoints and colour and enter SETUP; start SHALL be ignored outside IDLE.
REQ-019 SHALL, in SETUP (1 cycle), compute steep = |y1-y0| > |x1-x0|; if steep, swap x/y of each endpoint; then if xs > xe, swap the endpoints.
REQ-020 SHALL, in SETUP, compute dx = xe-xs, dy = |ye-ys|, ystep = +1 if ys < ye else -1, err = dx>>1, and x = xs, y = ys.
REQ-021 SHALL hold err as a signed WIDTH+1-bit value, with dx and dy as WIDTH-bit unsigned values.
REQ-022 SHALL, in DRAW, take one step per cycle only when the output register is free (frag_valid=0 or frag_ready=1).
REQ-023 SHALL plot each step at (col,row) = steep ? (y,x) : (x,y).
REQ-024 SHALL update each step as err -= dy; if err < 0 then y += ystep and err += dx; x += 1.
REQ-025 SHALL emit exactly dx+1 steps, in ascending order along the major axis regardless of endpoint order.
REQ-026 SHALL register FB_addr = row*FB_COLS + col, truncated to FB_W, and register the colour with frag_valid=1.
REQ-027 SHALL suppress a fragment whose col >= FB_COLS or row >= FB_ROWS: the step is consumed, frag_valid stays 0 for that step, and no address is computed for it.
REQ-028 SHALL hold FB_addr and the colour outputs stable while frag_valid=1 and frag_ready=0.
REQ-029 SHALL clear frag_valid on acceptance when no further fragment is produced in that cycle.
REQ-030 SHALL enter DONE once the last step is taken and its fragment, if any, is accepted.
REQ-031 SHALL assert finish for the single DONE cycle, after which busy SHALL fall.
REQ-032 SHALL make the first frag_valid visible 2 cycles after the start-sampling edge (edge 1: SETUP to DRAW; edge 2: first fragment registered).
REQ-033 SHALL, when x0=x1 and y0=y1, emit exactly one fragment.
REQ-034 SHALL, when start is held high, begin no new line until IDLE is re-entered; a start sampled in that IDLE cycle SHALL be accepted.

Reset
REQ-035 SHALL, while rst=0, force state IDLE and drive frag_valid, busy, finish, FB_addr and all colour outputs to 0, immediately and independent of clk.
REQ-036 SHALL abandon an in-progress line on reset with no finish pulse, and remain in IDLE after rst rises until start.

Verification
REQ-037 SHALL be verified by: (0,0)-(3,0), frag_ready=1 -> addrs 0,1,2,3 on consecutive cycles starting 2 cycles after start, then a finish pulse.
REQ-038 SHALL be verified by: steep line (5,10)-(6,13) -> addrs 3205, 3525, 3846, 4166.
REQ-039 SHALL be verified by: reversed line (3,0)-(0,0) -> addrs 0,1,2,3 in ascending order; single point (7,2) -> one fragment at addr 647.
REQ-040 SHALL be verified by: frag_ready low for 3 cycles on the second fragment of (0,0)-(3,0) -> addr 1 held stable, no fragment lost or duplicated.
REQ-041 SHALL be verified by: clipped line (318,0)-(321,0) -> only addrs 318 and 319, then a finish pulse.
REQ-042 SHALL be verified by: rst=0 asserted mid-DRAW -> all outputs 0 asynchronously, no finish pulse; a fresh start after release draws normally.
